cska_mp_seq: RTL and testbench

CSKA_MP_SEQ -- requirements
Module: cska_mp_seq

---
 rtl/cska_mp_seq.sv | 161 ++++++++++++++++
 tb/tb_cska_mp_seq.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cska_mp_seq.sv
// Multi-precision add/subtract sequencer.
// Streams two W-bit operands (W = WORD*WORDS) one word per cycle through an
// external combinational WORD-bit adder, least-significant word first,
// rippling the carry through a local carry register. The result is then
// presented with a valid/ready handshake.
module cska_mp_seq #(
  parameter int WORD  = 32,
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  // request side
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD*WORDS-1:0] op_a,
  input  logic [WORD*WORDS-1:0] op_b,
  input  logic                  sub,
  // result side
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD*WORDS-1:0] result,
  output logic                  carry_out,
  output logic                  overflow,
  // external word adder
  output logic [WORD-1:0]       add_a,
  output logic [WORD-1:0]       add_b,
  output logic                  add_cin,
  input  logic [WORD-1:0]       add_sum,
  input  logic                  add_cout
);

  // A single-word operation still needs a one-bit index register.
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  // Operands and result are held as word arrays so the current word is
  // selected by plain indexing with the word counter.
  logic [WORDS-1:0][WORD-1:0] a_q;
  logic [WORDS-1:0][WORD-1:0] b_q;
  logic [WORDS-1:0][WORD-1:0] res_q;
  logic                       sub_q;
  logic [IDX_W-1:0]           idx_q;
  logic                       carry_q;
  logic                       cout_q;
  logic                       ovf_q;

  logic accept;
  logic last_word;
  logic a_msb;
  logic beff_msb;

  assign accept    = (state_q == IDLE) && in_valid;
  assign last_word = (state_q == RUN) && (idx_q == LAST_IDX);

  // Sign bits of A and of the effective (possibly inverted) B.
  assign a_msb    = a_q[WORDS-1][WORD-1];
  assign beff_msb = b_q[WORDS-1][WORD-1] ^ sub_q;

  assign result    = res_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode, handshake outputs and adder drives.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned, which would infer a latch.
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = RUN;
        end
      end
      RUN: begin
        add_a   = a_q[idx_q];
        add_b   = b_q[idx_q] ^ {WORD{sub_q}};
        // Word 0 takes the operation carry-in (1 completes the two's
        // complement of B); later words take the rippled carry.
        add_cin = (idx_q == '0) ? sub_q : carry_q;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operand capture on acceptance; held untouched until the next request.
  always_ff @(posedge clk) begin
    // NOTE: the operand registers are deliberately left out of reset: they
    // are always loaded on acceptance before anything reads them, and
    // keeping them reset-free keeps a wide register bank cheap.
    if (accept) begin
      a_q   <= op_a;
      b_q   <= op_b;
      sub_q <= sub;
    end
  end

  // Word-serial datapath: result words, carry ripple, word index and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      // Clear the result so words not yet written read as zero during RUN.
      res_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
    end else if (state_q == RUN) begin
      res_q[idx_q] <= add_sum;
      carry_q      <= add_cout;
      if (last_word) begin
        idx_q  <= '0;
        cout_q <= add_cout;
        // Signed overflow: operands agree in sign but the sum does not.
        ovf_q  <= (a_msb == beff_msb) && (add_sum[WORD-1] != a_msb);
      end else begin
        idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cska_mp_seq.sv
// Testbench for cska_mp_seq (WORD=32, WORDS=4) with a behavioural word adder
// on the add_* ports. Stimulus pushes expected results into a queue; a
// monitor pops and compares on every result handoff.
module tb_cska_mp_seq;

  localparam int WORD  = 32;
  localparam int WORDS = 4;
  localparam int W     = WORD * WORDS;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         o;
  } exp_t;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    op_a;
  logic [W-1:0]    op_b;
  logic            sub;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    result;
  logic            carry_out;
  logic            overflow;
  logic [WORD-1:0] add_a;
  logic [WORD-1:0] add_b;
  logic            add_cin;
  logic [WORD-1:0] add_sum;
  logic            add_cout;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   n_pop   = 0;
  exp_t exp_q[$];

  cska_mp_seq #(.WORD(WORD), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout)
  );

  // Combinational word adder returning sum and carry in the same cycle.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{WORD{1'b0}}, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got timeout expected DUT response", name);
  endtask

  function automatic exp_t mk(input logic [W-1:0] r, input logic c, input logic o);
    exp_t e;
    e.r = r;
    e.c = c;
    e.o = o;
    return e;
  endfunction

  // Full-width reference for the random sweep.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [W-1:0] be;
    logic [W:0]   t;
    be = s ? ~b : b;
    t  = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, s};
    return mk(t[W-1:0], t[W], (a[W-1] == be[W-1]) && (t[W-1] != a[W-1]));
  endfunction

  function automatic logic [W-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor: compare every handoff against the head of the queue.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 1'b1, 1'b0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check($sformatf("result#%0d", n_pop), result, e.r);
        check($sformatf("carry#%0d", n_pop), carry_out, e.c);
        check($sformatf("overflow#%0d", n_pop), overflow, e.o);
        n_pop++;
      end
    end
  end

  // Present a request, wait for acceptance, optionally push the expectation,
  // then scramble the inputs to show the captured operands are held.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic push, input exp_t e);
    int n;
    n = 0;
    op_a     = a;
    op_b     = b;
    sub      = s;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) timeout("issue_accept");
    @(posedge clk);
    if (push) exp_q.push_back(e);
    #1;
    in_valid = 1'b0;
    op_a     = rnd();
    op_b     = rnd();
    sub      = ~s;
  endtask

  task automatic wait_handoff(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(out_valid && out_ready) && n < 60);
    if (n >= 60) timeout(name);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int prev;
    int c;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic s;

    rst       = 1'b1;
    in_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    sub       = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);

    // Reset state.
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", result, '0);
    check("rst_carry", carry_out, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_add_a", add_a, '0);
    check("rst_add_cin", add_cin, 1'b0);

    // All-ones plus one: carry ripples through every word.
    issue({W{1'b1}}, 128'd1, 1'b0, 1'b1, mk('0, 1'b1, 1'b0));
    for (int i = 0; i < WORDS; i++) begin
      @(negedge clk);
      check($sformatf("t1_cin%0d", i), add_cin, (i == 0) ? 1'b0 : 1'b1);
      check($sformatf("t1_busy%0d", i), out_valid, 1'b0);
      @(posedge clk);
    end
    @(negedge clk);
    check("t1_latency", out_valid, 1'b1);
    @(posedge clk);
    #1;
    check("t1_back_idle", in_ready, 1'b1);

    // 5 - 7 = -2, borrow, no overflow.
    issue(128'd5, 128'd7, 1'b1, 1'b1, mk({{(W-1){1'b1}}, 1'b0}, 1'b0, 1'b0));
    @(negedge clk);
    check("t2_add_a0", add_a, 32'd5);
    check("t2_add_b0", add_b, 32'hFFFF_FFF8);
    check("t2_add_cin0", add_cin, 1'b1);
    wait_handoff("t2_handoff");

    // Max positive plus one overflows to min negative.
    issue({1'b0, {(W-1){1'b1}}}, 128'd1, 1'b0, 1'b1, mk({1'b1, {(W-1){1'b0}}}, 1'b0, 1'b1));
    wait_handoff("t3_handoff");

    // Backpressure: result held with a competing request pending.
    out_ready = 1'b0;
    issue(128'h1234, 128'h10, 1'b0, 1'b1, mk(128'h1244, 1'b0, 1'b0));
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 20) timeout("bp_done");
    op_a     = 128'd100;
    op_b     = 128'd1;
    sub      = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_hold_res%0d", i), result, 128'h1244);
      check($sformatf("bp_hold_valid%0d", i), out_valid, 1'b1);
      check($sformatf("bp_hold_ready%0d", i), in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_idle_valid", out_valid, 1'b0);
    check("bp_idle_ready", in_ready, 1'b1);
    exp_q.push_back(mk(128'd99, 1'b1, 1'b0));
    @(posedge clk);
    #1;
    check("bp_accept", in_ready, 1'b0);
    in_valid = 1'b0;
    wait_handoff("bp_handoff");

    // Reset in the middle of RUN aborts the operation.
    issue({4{32'h1111_1111}}, {4{32'h2222_2222}}, 1'b0, 1'b0, mk('0, 1'b0, 1'b0));
    @(posedge clk);
    @(posedge clk);
    #1;
    check("abort_partial", result, {64'd0, 64'h3333_3333_3333_3333});
    #1;
    rst = 1'b1;
    #1;
    check("abort_valid", out_valid, 1'b0);
    check("abort_result", result, '0);
    check("abort_ready", in_ready, 1'b1);
    check("abort_add_a", add_a, '0);
    @(negedge clk);
    rst = 1'b0;
    issue(128'd3, 128'd4, 1'b0, 1'b1, mk(128'd7, 1'b0, 1'b0));
    wait_handoff("abort_next");

    // Back-to-back random traffic with in_valid held high.
    prev = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      a = rnd();
      b = rnd();
      s = 1'($urandom_range(0, 1));
      op_a = a;
      op_b = b;
      sub  = s;
      n = 0;
      while (!in_ready && n < 20) begin
        @(posedge clk);
        #1;
        n++;
      end
      if (n >= 20) timeout("b2b_accept");
      @(posedge clk);
      exp_q.push_back(model(a, b, s));
      #1;
      c = cyc;
      if (i > 0) check($sformatf("b2b_gap%0d", i), 32'(c - prev), 32'(WORDS + 2));
      prev = c;
    end
    in_valid = 1'b0;

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
